btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples required to accept a level change; legal range 1..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a_raw  input  1  raw entry-sensor/button A level, asynchronous to clk, 1 = pressed/blocked.
REQ-005 b_raw  input  1  raw sensor/button B level, same semantics as a_raw.
REQ-006 a_btn  output  1  debounced level of A; feeds the parking counter's a_btn input.
REQ-007 b_btn  output  1  debounced level of B; feeds the parking counter's b_btn input.
REQ-008 a_rise, a_fall  output  1 each  single-cycle pulses marking accepted 0->1 / 1->0 changes of a_btn.
REQ-009 b_rise, b_fall  output  1 each  single-cycle pulses marking accepted 0->1 / 1->0 changes of b_btn.

Function
REQ-010 Channels A and B SHALL be identical and fully independent; no shared state.
REQ-011 Each channel SHALL pass its raw input through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-012 Each channel SHALL hold a debounce counter of width ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-013 Per edge: if sync2 == level, counter SHALL clear to 0 and level SHALL hold.
REQ-014 Per edge: if sync2 != level and counter == DEBOUNCE_CYCLES-1, level SHALL take sync2 and counter SHALL clear to 0.
REQ-015 Per edge: if sync2 != level and counter < DEBOUNCE_CYCLES-1, counter SHALL increment by 1 and level SHALL hold.
REQ-016 Latency: raw change first sampled at edge 0 and held SHALL update the level output at edge DEBOUNCE_CYCLES+1, no earlier and no later.
REQ-017 Any return of sync2 to the current level before acceptance SHALL restart the count from 0; glitches shorter than DEBOUNCE_CYCLES synchronized samples SHALL never change the level.
REQ-018 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-019 rise (fall) SHALL be high for exactly the one cycle following the edge at which level changed 0->1 (1->0), i.e. coincident with the new level value.
REQ-020 rise and fall of one channel SHALL never be high together; two accepted changes on one channel SHALL be at least DEBOUNCE_CYCLES cycles apart.
REQ-021 Simultaneous changes on A and B SHALL be accepted on the same edge with both pulses asserted in the same cycle.
REQ-022 DEBOUNCE_CYCLES = 1 SHALL accept a change on the first mismatching synchronized sample (latency 2 edges).
REQ-023 Outputs SHALL be registered; no combinational path from a_raw/b_raw to any output.

Reset
REQ-024 While reset = 1, sync1, sync2, counter, level and pulse registers SHALL be 0 immediately, independent of clk.
REQ-025 Reset outputs: a_btn = b_btn = 0, all rise/fall = 0.
REQ-026 Reset asserted mid-count SHALL discard the partial count; after release, a held-high raw input SHALL need the full DEBOUNCE_CYCLES+1 edges, counted from the first edge after release, before acceptance.
REQ-027 A raw input held high through reset SHALL, after release, produce a normal a_rise/b_rise pulse on acceptance.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 a_raw 0->1 before edge 0, held 10 cycles -> a_btn = 1 from edge 5, a_rise high exactly one cycle, b outputs remain 0.
REQ-029 a_raw high for 3 cycles then low -> a_btn stays 0, no a_rise/a_fall at any time.
REQ-030 Bounce: a_raw 1,0,1,1,0 per cycle, then 1 held -> a_btn rises exactly 5 edges after the final 0->1 sample; single a_rise.
REQ-031 From a_btn = 1, a_raw -> 0 held -> a_btn = 0 at edge 5 after the first low sample, one a_fall pulse, no a_rise.
REQ-032 a_raw and b_raw rise on the same cycle -> a_btn and b_btn rise on the same edge, a_rise and b_rise asserted together.
REQ-033 a_raw held high, reset pulsed at edge 3 mid-count -> all outputs 0 asynchronously; a_btn rises at edge 5 after release, not before.

Source files
------------

// File: rtl/btn_conditioner.sv
// Two-channel button/sensor conditioner.
// Each channel synchronises its raw input, debounces it, and emits
// single-cycle rise/fall pulses. The two channels share no state.

module btn_conditioner_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;

  // Next-state: synchroniser shift, debounce count and acceptance pulses
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q == level_q) begin
      // Input agrees with the accepted level: any partial count is discarded
      cnt_d = CNT_ZERO;
    end else if (cnt_q >= CNT_LAST) begin
      // Enough consecutive mismatching samples: accept the new level.
      // Using >= keeps the counter from ever running past the last value.
      cnt_d   = CNT_ZERO;
      level_d = sync2_q;
      rise_d  = sync2_q;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_btn,
  output logic b_btn,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  btn_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_a (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (a_raw),
    .level_o(a_btn),
    .rise_o (a_rise),
    .fall_o (a_fall)
  );

  btn_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_b (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (b_raw),
    .level_o(b_btn),
    .rise_o (b_rise),
    .fall_o (b_fall)
  );

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner.
// Output vectors are packed as {a_btn, a_rise, a_fall, b_btn, b_rise, b_fall}.

module tb_btn_conditioner;

  logic clk;
  logic reset;
  logic a_raw, b_raw;
  logic a_btn, b_btn, a_rise, a_fall, b_rise, b_fall;

  // Second instance with the minimum debounce length
  logic a1_raw, b1_raw;
  logic a1_btn, b1_btn, a1_rise, a1_fall, b1_rise, b1_fall;

  int checks;
  int failures;

  btn_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a_btn (a_btn),
    .b_btn (b_btn),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .a_raw (a1_raw),
    .b_raw (b1_raw),
    .a_btn (a1_btn),
    .b_btn (b1_btn),
    .a_rise(a1_rise),
    .a_fall(a1_fall),
    .b_rise(b1_rise),
    .b_fall(b1_fall)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {a_btn, a_rise, a_fall, b_btn, b_rise, b_fall};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {a1_btn, a1_rise, a1_fall, b1_btn, b1_rise, b1_fall};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] exp;
    logic [4:0] bounce;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    a_raw    = 1'b0;
    b_raw    = 1'b0;
    a1_raw   = 1'b0;
    b1_raw   = 1'b0;

    // Reset state
    step();
    step();
    chk("reset_state", 6'b000000);
    chk1("reset_state_d1", 6'b000000);
    reset = 1'b0;
    step();
    step();
    chk("idle_after_reset", 6'b000000);

    // Clean press on A: level at edge 5, single rise, B untouched
    a_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k < 5)       exp = 6'b000000;
      else if (k == 5) exp = 6'b110000;
      else             exp = 6'b100000;
      chk($sformatf("a_press_e%0d", k), exp);
    end

    // Release of A: level drops at edge 5, single fall, no rise
    a_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k < 5)       exp = 6'b100000;
      else if (k == 5) exp = 6'b001000;
      else             exp = 6'b000000;
      chk($sformatf("a_release_e%0d", k), exp);
    end

    // Short pulse (3 samples) must never be accepted
    a_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) a_raw = 1'b0;
      step();
      chk($sformatf("a_glitch_e%0d", k), 6'b000000);
    end

    // Bounce 1,0,1,1,0 then held high: final 0->1 sample at edge 5,
    // accepted at edge 10
    bounce = 5'b01101;
    for (int k = 0; k < 14; k++) begin
      a_raw = (k < 5) ? bounce[k] : 1'b1;
      step();
      if (k < 10)       exp = 6'b000000;
      else if (k == 10) exp = 6'b110000;
      else              exp = 6'b100000;
      chk($sformatf("a_bounce_e%0d", k), exp);
    end

    // Return A to idle
    a_raw = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("a_idle_again", 6'b000000);

    // Simultaneous press on A and B
    a_raw = 1'b1;
    b_raw = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      if (k < 5)       exp = 6'b000000;
      else if (k == 5) exp = 6'b110110;
      else             exp = 6'b100100;
      chk($sformatf("ab_press_e%0d", k), exp);
    end

    // Simultaneous release on A and B
    a_raw = 1'b0;
    b_raw = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      if (k < 5)       exp = 6'b100100;
      else if (k == 5) exp = 6'b001001;
      else             exp = 6'b000000;
      chk($sformatf("ab_release_e%0d", k), exp);
    end

    // Bring B high so the asynchronous clear has something to clear
    b_raw = 1'b1;
    for (int k = 0; k < 7; k++) step();
    chk("b_held_high", 6'b000100);

    // A pressed, reset pulsed mid-count after edge 2
    a_raw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("a_midcount_e%0d", k), 6'b000100);
    end
    reset = 1'b1;
    #2;
    chk("async_reset_clear", 6'b000000);
    step();
    chk("reset_held_edge", 6'b000000);
    reset = 1'b0;

    // Both raw inputs held through reset: full latency counted from release
    for (int k = 0; k < 7; k++) begin
      step();
      if (k < 5)       exp = 6'b000000;
      else if (k == 5) exp = 6'b110110;
      else             exp = 6'b100100;
      chk($sformatf("post_reset_e%0d", k), exp);
    end

    // Minimum debounce length: accepted two edges after the change
    a1_raw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k < 2)       exp = 6'b000000;
      else if (k == 2) exp = 6'b110000;
      else             exp = 6'b100000;
      chk1($sformatf("d1_press_e%0d", k), exp);
    end
    a1_raw = 1'b0;
    b1_raw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k < 2)       exp = 6'b100000;
      else if (k == 2) exp = 6'b001110;
      else             exp = 6'b000100;
      chk1($sformatf("d1_swap_e%0d", k), exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
